// File: rtl/matrix_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mult_seq
// Purpose  : Load/multiply/store sequencer around a 4x4 16-bit matrix
//            multiplier. On a start pulse it reads matrix A and matrix B
//            (16 words each) from data memory and packs them into 256-bit
//            buses. It then enables the multiplier and waits for its done
//            flag. Finally it writes the 256-bit product back to memory as
//            16 words.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        one-cycle request, accepted only in IDLE
//   addr_a/b/r   base word addresses of A, B and result (latched on start)
//   busy         high from cycle after accepted start until back in IDLE
//   finished     one-cycle pulse after the last result word is written
//   mem_addr     registered memory word address
//   mem_rd       read request  (never high together with mem_wr)
//   mem_wr       write request
//   mem_wdata    registered write data
//   mem_rdata    read data, valid while mem_ack is high
//   mem_ack      completes the current read/write transfer
//   m1, m2       packed A and B to the multiplier, element (r,c) at
//                bits [r*64+c*16 +: 16] == memory word k=4r+c
//   mult_enable  multiplier enable
//   mult_done    multiplier done flag
//   m_out        packed product from the multiplier
// ============================================================================
module matrix_mult_seq #(
    parameter int AW     = 8,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] addr_r,
    output logic          busy,
    output logic          finished,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ack,
    output logic [255:0]  m1,
    output logic [255:0]  m2,
    output logic          mult_enable,
    input  logic          mult_done,
    input  logic [255:0]  m_out
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD_A = 3'd1;
    localparam logic [2:0] c_ST_LOAD_B = 3'd2;
    localparam logic [2:0] c_ST_MUL    = 3'd3;
    localparam logic [2:0] c_ST_STORE  = 3'd4;
    localparam logic [2:0] c_ST_FIN    = 3'd5;

    localparam logic [3:0] c_SETTLE    = 4'(SETTLE);
    localparam logic [3:0] c_LAST_WORD = 4'hF;

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    logic [2:0]    r_state_q,  w_state_d;
    logic [3:0]    r_k_q,      w_k_d;
    logic [3:0]    r_settle_q, w_settle_d;
    logic [AW-1:0] r_base_a_q, w_base_a_d;
    logic [AW-1:0] r_base_b_q, w_base_b_d;
    logic [AW-1:0] r_base_r_q, w_base_r_d;
    logic [255:0]  r_m1_q,     w_m1_d;
    logic [255:0]  r_m2_q,     w_m2_d;
    logic [255:0]  r_res_q,    w_res_d;
    logic          r_busy_q,   w_busy_d;
    logic          r_fin_q,    w_fin_d;
    logic [AW-1:0] r_addr_q,   w_addr_d;
    logic          r_rd_q,     w_rd_d;
    logic          r_wr_q,     w_wr_d;
    logic [15:0]   r_wdata_q,  w_wdata_d;
    logic          r_men_q,    w_men_d;

    // Helpers
    logic [3:0]    w_k_inc;
    logic          w_last;
    logic          w_rd_done;
    logic          w_wr_done;
    logic [7:0]    w_bit_k;
    logic [7:0]    w_bit_k_inc;

    assign w_k_inc     = r_k_q + 4'd1;
    assign w_last      = (r_k_q == c_LAST_WORD);
    // An ack only counts while the matching request is actually asserted.
    assign w_rd_done   = r_rd_q & mem_ack;
    assign w_wr_done   = r_wr_q & mem_ack;
    // Word k of a packed matrix starts at bit 16*k (row-major, 4 per row).
    assign w_bit_k     = {r_k_q, 4'b0000};
    assign w_bit_k_inc = {w_k_inc, 4'b0000};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_k_d      = r_k_q;
        w_settle_d = r_settle_q;
        w_base_a_d = r_base_a_q;
        w_base_b_d = r_base_b_q;
        w_base_r_d = r_base_r_q;
        w_m1_d     = r_m1_q;
        w_m2_d     = r_m2_q;
        w_res_d    = r_res_q;
        w_busy_d   = r_busy_q;
        w_fin_d    = 1'b0;
        w_addr_d   = r_addr_q;
        w_rd_d     = r_rd_q;
        w_wr_d     = r_wr_q;
        w_wdata_d  = r_wdata_q;
        w_men_d    = r_men_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (start) begin
                    w_base_a_d = addr_a;
                    w_base_b_d = addr_b;
                    w_base_r_d = addr_r;
                    w_k_d      = 4'd0;
                    w_busy_d   = 1'b1;
                    w_rd_d     = 1'b1;
                    w_addr_d   = addr_a;
                    w_state_d  = c_ST_LOAD_A;
                end
            end

            c_ST_LOAD_A: begin
                if (w_rd_done) begin
                    w_m1_d[w_bit_k +: 16] = mem_rdata;
                    if (w_last) begin
                        // Request stays high: first B word is back-to-back.
                        w_k_d     = 4'd0;
                        w_addr_d  = r_base_b_q;
                        w_state_d = c_ST_LOAD_B;
                    end else begin
                        w_k_d    = w_k_inc;
                        w_addr_d = r_base_a_q + AW'(w_k_inc);
                    end
                end
            end

            c_ST_LOAD_B: begin
                if (w_rd_done) begin
                    w_m2_d[w_bit_k +: 16] = mem_rdata;
                    if (w_last) begin
                        w_k_d      = 4'd0;
                        w_rd_d     = 1'b0;
                        w_men_d    = 1'b1;
                        w_settle_d = 4'd0;
                        w_state_d  = c_ST_MUL;
                    end else begin
                        w_k_d    = w_k_inc;
                        w_addr_d = r_base_b_q + AW'(w_k_inc);
                    end
                end
            end

            c_ST_MUL: begin
                // mult_done is ignored until enable has been held SETTLE
                // cycles, so a stale done from a previous product (before
                // the multiplier pulls it low) is never taken as completion.
                if (r_settle_q != c_SETTLE) begin
                    w_settle_d = r_settle_q + 4'd1;
                end else if (mult_done) begin
                    w_res_d   = m_out;
                    w_men_d   = 1'b0;
                    w_wr_d    = 1'b1;
                    w_addr_d  = r_base_r_q;
                    // The result register is loaded on this same edge, so
                    // word 0 is taken straight from the product bus.
                    w_wdata_d = m_out[15:0];
                    w_k_d     = 4'd0;
                    w_state_d = c_ST_STORE;
                end
            end

            c_ST_STORE: begin
                if (w_wr_done) begin
                    if (w_last) begin
                        w_wr_d    = 1'b0;
                        w_k_d     = 4'd0;
                        w_fin_d   = 1'b1;
                        w_state_d = c_ST_FIN;
                    end else begin
                        w_k_d     = w_k_inc;
                        w_addr_d  = r_base_r_q + AW'(w_k_inc);
                        w_wdata_d = r_res_q[w_bit_k_inc +: 16];
                    end
                end
            end

            c_ST_FIN: begin
                w_busy_d  = 1'b0;
                w_state_d = c_ST_IDLE;
            end

            default: begin
                w_busy_d  = 1'b0;
                w_rd_d    = 1'b0;
                w_wr_d    = 1'b0;
                w_men_d   = 1'b0;
                w_k_d     = 4'd0;
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers (reset aborts any sequence immediately)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= c_ST_IDLE;
            r_k_q      <= 4'd0;
            r_settle_q <= 4'd0;
            r_base_a_q <= '0;
            r_base_b_q <= '0;
            r_base_r_q <= '0;
            r_m1_q     <= '0;
            r_m2_q     <= '0;
            r_res_q    <= '0;
            r_busy_q   <= 1'b0;
            r_fin_q    <= 1'b0;
            r_addr_q   <= '0;
            r_rd_q     <= 1'b0;
            r_wr_q     <= 1'b0;
            r_wdata_q  <= 16'd0;
            r_men_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_k_q      <= w_k_d;
            r_settle_q <= w_settle_d;
            r_base_a_q <= w_base_a_d;
            r_base_b_q <= w_base_b_d;
            r_base_r_q <= w_base_r_d;
            r_m1_q     <= w_m1_d;
            r_m2_q     <= w_m2_d;
            r_res_q    <= w_res_d;
            r_busy_q   <= w_busy_d;
            r_fin_q    <= w_fin_d;
            r_addr_q   <= w_addr_d;
            r_rd_q     <= w_rd_d;
            r_wr_q     <= w_wr_d;
            r_wdata_q  <= w_wdata_d;
            r_men_q    <= w_men_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy        = r_busy_q;
    assign finished    = r_fin_q;
    assign mem_addr    = r_addr_q;
    assign mem_rd      = r_rd_q;
    assign mem_wr      = r_wr_q;
    assign mem_wdata   = r_wdata_q;
    assign m1          = r_m1_q;
    assign m2          = r_m2_q;
    assign mult_enable = r_men_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mult_seq
// Purpose  : Directed self-checking bench for matrix_mult_seq. Provides a
//            256-word memory with programmable ack spacing and a multiplier
//            stand-in (real product with programmable done latency, or a
//            per-cycle marker pattern with done held high).
// Revision : 1.0  initial release
// ============================================================================
module tb_matrix_mult_seq;
    localparam int AW     = 8;
    localparam int SETTLE = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] addr_a, addr_b, addr_r;
    logic          busy, finished;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic          mem_ack;
    logic [255:0]  m1, m2, m_out;
    logic          mult_enable, mult_done;

    matrix_mult_seq #(.AW(AW), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r),
        .busy(busy), .finished(finished),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .m1(m1), .m2(m2), .mult_enable(mult_enable),
        .mult_done(mult_done), .m_out(m_out)
    );

    logic [15:0] mem [256];
    int          ack_every;
    int          mult_mode;   // 0: real product, 1: marker pattern, done=1
    int          done_lat;
    int          fin_count, wr_count, stall_viol, both_viol;
    logic [7:0]  rd_log [$];
    int          total, bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] matmul(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] res;
        logic [15:0]  s;
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 16'd0;
                for (int k = 0; k < 4; k++)
                    s = s + 16'(a[r*64+k*16 +: 16] * b[k*64+c*16 +: 16]);
                res[r*64+c*16 +: 16] = s;
            end
        return res;
    endfunction

    function automatic logic [255:0] pattern(input int n);
        logic [255:0] p;
        for (int i = 0; i < 16; i++) p[i*16 +: 16] = 16'((n << 8) + i);
        return p;
    endfunction

    // Memory model: responds on the falling edge so the DUT sees ack/rdata
    // at the following rising edge.
    initial begin
        int          acnt;
        bit          preq, pack;
        logic [7:0]  paddr;
        logic [15:0] pwd;
        acnt = 0; preq = 0; pack = 0; paddr = '0; pwd = '0;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (mem_rd && mem_wr) both_viol++;
            if (finished) fin_count++;
            if ((mem_rd || mem_wr) && preq && !pack &&
                (mem_addr !== paddr || (mem_wr && mem_wdata !== pwd)))
                stall_viol++;
            preq  = mem_rd || mem_wr;
            paddr = mem_addr;
            pwd   = mem_wdata;
            if (preq && acnt >= ack_every - 1) begin
                acnt    = 0;
                mem_ack = 1'b1;
                if (mem_rd) begin
                    mem_rdata = mem[mem_addr];
                    rd_log.push_back(mem_addr);
                end else begin
                    mem[mem_addr] = mem_wdata;
                    wr_count++;
                end
            end else begin
                if (preq) acnt++;
                mem_ack   = 1'b0;
                mem_rdata = 16'hBAD0;
            end
            pack = mem_ack;
        end
    end

    // Multiplier stand-in
    initial begin
        int mcyc;
        mcyc = 0; mult_done = 1'b1; m_out = '0;
        forever begin
            @(negedge clk);
            if (mult_enable) begin
                if (mult_mode == 1) begin
                    mult_done = 1'b1;
                    m_out     = pattern(mcyc);
                end else begin
                    mult_done = (mcyc >= done_lat);
                    m_out     = mult_done ? matmul(m1, m2) : {16{16'hDEAD}};
                end
                mcyc++;
            end else begin
                mcyc      = 0;
                mult_done = 1'b1;  // stale done from a previous product
                m_out     = (mult_mode == 1) ? pattern(255) : {16{16'hDEAD}};
            end
        end
    end

    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                           output int cyc, output bit tmo);
        @(negedge clk);
        start = 1'b1; addr_a = a; addr_b = b; addr_r = r;
        cyc = 0; tmo = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (finished) begin
                tmo = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_identity_ops();
        for (int k = 0; k < 16; k++) begin
            mem[k]      = (k / 4 == k % 4) ? 16'd1 : 16'd0;
            mem[16 + k] = 16'(k + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (finished !== 1'b0)    begin bad++; $display("FAIL reset_finished got=%b want=0", finished); end
        total++; if ({mem_rd, mem_wr, mult_enable} !== 3'b000)
            begin bad++; $display("FAIL reset_req got=%b want=000", {mem_rd, mem_wr, mult_enable}); end
        total++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0)
            begin bad++; $display("FAIL reset_addr_data got=%h/%h want=00/0000", mem_addr, mem_wdata); end
        total++; if (m1 !== '0 || m2 !== '0)
            begin bad++; $display("FAIL reset_m1m2 got=%h/%h want=0", m1, m2); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int cyc; bit tmo; int f0, w0;
        logic [255:0] exp_m1;
        load_identity_ops();
        for (int k = 0; k < 16; k++) mem[32 + k] = 16'h0;
        ack_every = 1; mult_mode = 0; done_lat = 2;
        f0 = fin_count; w0 = wr_count;
        run_seq(8'h00, 8'h10, 8'h20, cyc, tmo);
        total++;
        if (tmo || cyc < 51 || cyc > 53)
            begin bad++; $display("FAIL ident_latency got=%0d timeout=%0b want=52", cyc, tmo); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ident_busy_after got=%b want=0", busy); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (mem[32 + k] !== 16'(k + 1))
                begin bad++; $display("FAIL ident_word%0d got=%h want=%h", k, mem[32 + k], 16'(k + 1)); end
        end
        total++; if (fin_count - f0 !== 1) begin bad++; $display("FAIL ident_fin_count got=%0d want=1", fin_count - f0); end
        total++; if (wr_count - w0 !== 16) begin bad++; $display("FAIL ident_wr_count got=%0d want=16", wr_count - w0); end
        exp_m1 = '0;
        for (int k = 0; k < 4; k++) exp_m1[k*80 +: 16] = 16'd1;
        total++; if (m1 !== exp_m1) begin bad++; $display("FAIL ident_m1_retained got=%h want=%h", m1, exp_m1); end
    endtask

    task automatic test_wait_states();
        int cyc; bit tmo;
        for (int k = 0; k < 16; k++) begin
            mem[8'h40 + k] = 16'd2;
            mem[8'h50 + k] = 16'd3;
            mem[8'h60 + k] = 16'h0;
        end
        ack_every = 3; mult_mode = 0; done_lat = 5; stall_viol = 0;
        run_seq(8'h40, 8'h50, 8'h60, cyc, tmo);
        total++; if (tmo) begin bad++; $display("FAIL wait_timeout got=%0d want=finish", cyc); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (mem[8'h60 + k] !== 16'h0018)
                begin bad++; $display("FAIL wait_word%0d got=%h want=0018", k, mem[8'h60 + k]); end
        end
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL wait_stable got=%0d want=0", stall_viol); end
        ack_every = 1;
    endtask

    task automatic test_wrap();
        int cyc; bit tmo;
        logic [255:0] pa, pb, pr;
        for (int k = 0; k < 16; k++) begin
            mem[8'(252 + k)] = 16'(k + 1);
            mem[8'h80 + k]   = 16'(3 * k + 2);
            mem[8'hA0 + k]   = 16'h0;
            pa[k*16 +: 16]   = 16'(k + 1);
            pb[k*16 +: 16]   = 16'(3 * k + 2);
        end
        pr = matmul(pa, pb);
        ack_every = 1; mult_mode = 0; done_lat = 3;
        rd_log.delete();
        run_seq(8'hFC, 8'h80, 8'hA0, cyc, tmo);
        total++;
        if (tmo || rd_log.size() != 32)
            begin bad++; $display("FAIL wrap_reads got=%0d timeout=%0b want=32", rd_log.size(), tmo); end
        else
            for (int k = 0; k < 16; k++) begin
                total++;
                if (rd_log[k] !== 8'(252 + k))
                    begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", k, rd_log[k], 8'(252 + k)); end
            end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (mem[8'hA0 + k] !== pr[k*16 +: 16])
                begin bad++; $display("FAIL wrap_word%0d got=%h want=%h", k, mem[8'hA0 + k], pr[k*16 +: 16]); end
        end
    endtask

    task automatic test_done_gating();
        int cyc; bit tmo;
        load_identity_ops();
        for (int k = 0; k < 16; k++) mem[8'hB0 + k] = 16'h0;
        ack_every = 1; mult_mode = 1;
        run_seq(8'h00, 8'h10, 8'hB0, cyc, tmo);
        total++; if (tmo) begin bad++; $display("FAIL gate_timeout got=%0d want=finish", cyc); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (mem[8'hB0 + k] !== 16'(16'h0200 + k))
                begin bad++; $display("FAIL gate_word%0d got=%h want=%h", k, mem[8'hB0 + k], 16'(16'h0200 + k)); end
        end
        mult_mode = 0;
    endtask

    task automatic test_reset_mid_load();
        int cyc; bit tmo, hit; int f0;
        load_identity_ops();
        for (int k = 0; k < 16; k++) mem[32 + k] = 16'h0;
        ack_every = 1; mult_mode = 0; done_lat = 2;
        @(negedge clk);
        start = 1'b1; addr_a = 8'h00; addr_b = 8'h10; addr_r = 8'h20;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_rd && mem_addr == 8'h17) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL rst_reach_k7 got=0 want=1"); end
        f0 = fin_count;
        reset = 1'b1;
        #1;
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL rst_rd_drop got=%b want=0", mem_rd); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (fin_count !== f0) begin bad++; $display("FAIL rst_no_finish got=%0d want=%0d", fin_count, f0); end
        total++; if (mem[32] !== 16'h0) begin bad++; $display("FAIL rst_no_write got=%h want=0000", mem[32]); end
        rd_log.delete();
        run_seq(8'h00, 8'h10, 8'h20, cyc, tmo);
        total++;
        if (tmo || rd_log.size() == 0 || rd_log[0] !== 8'h00)
            begin bad++; $display("FAIL rst_restart_k0 got=%0d timeout=%0b want=00", rd_log.size(), tmo); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (mem[32 + k] !== 16'(k + 1))
                begin bad++; $display("FAIL rst_rerun_word%0d got=%h want=%h", k, mem[32 + k], 16'(k + 1)); end
        end
    endtask

    task automatic test_start_in_store();
        int f0, w0; bit sent, done_seen;
        load_identity_ops();
        for (int k = 0; k < 16; k++) mem[8'h70 + k] = 16'h0;
        mem[8'hC0] = 16'h5A5A;
        ack_every = 1; mult_mode = 0; done_lat = 2;
        f0 = fin_count; w0 = wr_count;
        @(negedge clk);
        start = 1'b1; addr_a = 8'h00; addr_b = 8'h10; addr_r = 8'h70;
        sent = 1'b0; done_seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mem_wr && !sent) begin
                start = 1'b1; addr_a = 8'h40; addr_r = 8'hC0; sent = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (finished) begin done_seen = 1'b1; break; end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (!done_seen || !sent)
            begin bad++; $display("FAIL store_start_run got=%0b/%0b want=1/1", done_seen, sent); end
        total++; if (fin_count - f0 !== 1) begin bad++; $display("FAIL store_fin_count got=%0d want=1", fin_count - f0); end
        total++; if (wr_count - w0 !== 16) begin bad++; $display("FAIL store_wr_count got=%0d want=16", wr_count - w0); end
        total++; if (busy !== 1'b0 || mem_rd !== 1'b0)
            begin bad++; $display("FAIL store_idle got=%b%b want=00", busy, mem_rd); end
        total++; if (mem[8'hC0] !== 16'h5A5A) begin bad++; $display("FAIL store_no_second got=%h want=5a5a", mem[8'hC0]); end
        total++; if (mem[8'h7F] !== 16'd16) begin bad++; $display("FAIL store_last_word got=%h want=0010", mem[8'h7F]); end
        total++; if (both_viol !== 0) begin bad++; $display("FAIL rd_wr_exclusive got=%0d want=0", both_viol); end
    endtask

    initial begin
        total = 0; bad = 0;
        fin_count = 0; wr_count = 0; stall_viol = 0; both_viol = 0;
        ack_every = 1; mult_mode = 0; done_lat = 2;
        start = 1'b0; addr_a = '0; addr_b = '0; addr_r = '0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        test_reset();
        test_identity();
        test_wait_states();
        test_wrap();
        test_done_gating();
        test_reset_mid_load();
        test_start_in_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
